// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts decoded R-type, LUI and LW instructions,
// runs the data-memory read handshake for loads and issues one register-file write.
module wb_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] immediate,
    input  logic [31:0] alu_result,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        lui_control_signal,
    output logic        mem_error
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MEM_WAIT  = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic        lui_q, lui_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    // NOTE: every signal takes its held value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        lui_d   = lui_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    case (opcode)
                        OP_RTYPE: begin
                            wreg_d  = rd;
                            wdata_d = alu_result;
                            lui_d   = 1'b0;
                            state_d = WRITEBACK;
                        end
                        OP_LUI: begin
                            wreg_d  = rt;
                            wdata_d = {immediate, 16'h0000};
                            lui_d   = 1'b1;
                            state_d = WRITEBACK;
                        end
                        OP_LW: begin
                            wreg_d  = rt;
                            addr_d  = alu_result;
                            lui_d   = 1'b0;
                            cnt_d   = 8'd0;
                            state_d = MEM_WAIT;
                        end
                        default: ;  // unknown opcodes are consumed without a write
                    endcase
                end
            end
            MEM_WAIT: begin
                // Data arriving on the last allowed cycle still wins over the abort.
                if (mem_ready) begin
                    wdata_d = mem_rdata;
                    state_d = WRITEBACK;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
            addr_q  <= 32'd0;
            lui_q   <= 1'b0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            lui_q   <= lui_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign instr_ready        = (state_q == IDLE);
    assign mem_req            = (state_q == MEM_WAIT);
    assign mem_addr           = addr_q;
    // Writes to register 0 keep the WRITEBACK slot but never reach the register file.
    assign reg_write          = (state_q == WRITEBACK) && (wreg_q != 5'd0);
    assign write_reg          = wreg_q;
    assign write_data         = wdata_q;
    assign lui_control_signal = (state_q == WRITEBACK) && lui_q;
    assign mem_error          = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: a queue of expected register writes is
// filled by the stimulus and drained by an independent write monitor.
module tb_wb_sequencer;

    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        lui;
    } wb_exp_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] immediate;
    logic [31:0] alu_result;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        lui_control_signal;
    logic        mem_error;

    int n_cmp = 0;
    int n_err = 0;
    wb_exp_t exp_q[$];

    wb_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk                (clk),
        .reset              (reset),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .opcode             (opcode),
        .rt                 (rt),
        .rd                 (rd),
        .immediate          (immediate),
        .alu_result         (alu_result),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ready          (mem_ready),
        .mem_rdata          (mem_rdata),
        .reg_write          (reg_write),
        .write_reg          (write_reg),
        .write_data         (write_data),
        .lui_control_signal (lui_control_signal),
        .mem_error          (mem_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected one.
    always @(negedge clk) begin
        wb_exp_t e;
        if (reg_write === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got write_reg=%0d write_data=%h expected no write",
                         write_reg, write_data);
            end else begin
                e = exp_q.pop_front();
                if ({write_reg, write_data, lui_control_signal} !== {e.wreg, e.wdata, e.lui}) begin
                    n_err++;
                    $display("FAIL wb_beat: got reg=%0d data=%h lui=%b expected reg=%0d data=%h lui=%b",
                             write_reg, write_data, lui_control_signal, e.wreg, e.wdata, e.lui);
                end
            end
        end
    end

    task automatic expect_write(input logic [4:0] r, input logic [31:0] d, input logic l);
        wb_exp_t e;
        e.wreg  = r;
        e.wdata = d;
        e.lui   = l;
        exp_q.push_back(e);
    endtask

    // Presents one instruction for a single accepting edge; returns at edge+1.
    task automatic issue(input logic [5:0] op, input logic [4:0] t, input logic [4:0] d,
                         input logic [15:0] imm, input logic [31:0] alu);
        int n = 0;
        while (instr_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_before_issue", {31'd0, instr_ready}, 32'd1);
        opcode      = op;
        rt          = t;
        rd          = d;
        immediate   = imm;
        alu_result  = alu;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        opcode      = 6'b111111;
        alu_result  = 32'hCAFEF00D;
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        instr_valid = 1'b0;
        opcode      = 6'd0;
        rt          = 5'd0;
        rd          = 5'd0;
        immediate   = 16'd0;
        alu_result  = 32'd0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_write_reg", {27'd0, write_reg}, 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_lui", {31'd0, lui_control_signal}, 32'd0);
        check("rst_mem_error", {31'd0, mem_error}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // LUI: writes {imm,16'h0} to rt the cycle after acceptance.
        expect_write(5'd5, 32'hFFFF0000, 1'b1);
        issue(OP_LUI, 5'd5, 5'd9, 16'hFFFF, 32'h11111111);
        check("lui_wb_cycle", {31'd0, reg_write}, 32'd1);
        check("lui_busy", {31'd0, instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("lui_back_idle", {31'd0, instr_ready}, 32'd1);
        check("lui_ctrl_drop", {31'd0, lui_control_signal}, 32'd0);

        // R-type to rd.
        expect_write(5'd3, 32'hDEADBEEF, 1'b0);
        issue(OP_RTYPE, 5'd7, 5'd3, 16'h1234, 32'hDEADBEEF);

        // LW with data ready in the third MEM_WAIT cycle.
        expect_write(5'd8, 32'h55555555, 1'b0);
        issue(OP_LW, 5'd8, 5'd2, 16'h0040, 32'h00000040);
        for (int i = 0; i < 3; i++) begin
            check("lw_mem_req", {31'd0, mem_req}, 32'd1);
            check("lw_mem_addr", mem_addr, 32'h00000040);
            if (i == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h55555555;
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("lw_req_drop", {31'd0, mem_req}, 32'd0);
        check("lw_wb_cycle", {31'd0, reg_write}, 32'd1);

        // LW that never gets data: exactly 15 request cycles, sticky error, no write.
        mem_rdata = 32'hFFFFFFFF;
        issue(OP_LW, 5'd9, 5'd0, 16'h0080, 32'h00000080);
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("to_req_cycles", n, 32'd15);
        check("to_mem_error", {31'd0, mem_error}, 32'd1);
        check("to_idle", {31'd0, instr_ready}, 32'd1);
        check("to_no_write", {31'd0, reg_write}, 32'd0);

        // Error does not block further work and stays set.
        expect_write(5'd4, 32'hA5A5A5A5, 1'b0);
        issue(OP_RTYPE, 5'd1, 5'd4, 16'h0, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        check("err_sticky", {31'd0, mem_error}, 32'd1);

        reset = 1'b1;
        #1;
        check("rst_clears_err", {31'd0, mem_error}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // mem_ready on the final allowed cycle: data wins, no error.
        expect_write(5'd10, 32'h0BADF00D, 1'b0);
        issue(OP_LW, 5'd10, 5'd0, 16'h00C0, 32'h000000C0);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
        end
        check("coin_req_hold", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        check("coin_wb", {31'd0, reg_write}, 32'd1);
        check("coin_no_err", {31'd0, mem_error}, 32'd0);

        // R-type to r0: one busy cycle, no write.
        issue(OP_RTYPE, 5'd6, 5'd0, 16'h0, 32'h12345678);
        check("r0_busy", {31'd0, instr_ready}, 32'd0);
        check("r0_no_write", {31'd0, reg_write}, 32'd0);
        @(posedge clk);
        #1;
        check("r0_ready_back", {31'd0, instr_ready}, 32'd1);

        // Unknown opcode is consumed and the sequencer stays idle.
        issue(OP_BEQ, 5'd12, 5'd13, 16'h0010, 32'h77777777);
        check("other_stays_idle", {31'd0, instr_ready}, 32'd1);

        // Reset in the middle of a load: asynchronous clear, aborted load never writes.
        issue(OP_LW, 5'd11, 5'd0, 16'h0100, 32'h00000100);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("mid_rst_wreg", {27'd0, write_reg}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h99999999;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        check("mid_rst_idle_req", {31'd0, mem_req}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, default 15, max MEM_WAIT cycles without mem_ready before abort (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: instr_valid  input  1  decoded instruction fields valid.
REQ-005 SHALL have port: instr_ready  output  1  sequencer accepts instruction this cycle.
REQ-006 SHALL have port: opcode  input  6  instruction opcode.
REQ-007 SHALL have port: rt  input  5  rt field.
REQ-008 SHALL have port: rd  input  5  rd field.
REQ-009 SHALL have port: immediate  input  16  instruction immediate.
REQ-010 SHALL have port: alu_result  input  32  ALU output (R-type result or LW address).
REQ-011 SHALL have port: mem_req  output  1  data-memory read request.
REQ-012 SHALL have port: mem_addr  output  32  captured load address.
REQ-013 SHALL have port: mem_ready  input  1  memory read data valid.
REQ-014 SHALL have port: mem_rdata  input  32  memory read data.
REQ-015 SHALL have port: reg_write  output  1  register-file write enable.
REQ-016 SHALL have port: write_reg  output  5  destination register.
REQ-017 SHALL have port: write_data  output  32  writeback data.
REQ-018 SHALL have port: lui_control_signal  output  1  LUI writeback select to the LUI unit.
REQ-019 SHALL have port: mem_error  output  1  sticky load-timeout flag.

Function
REQ-020 SHALL implement FSM states IDLE, MEM_WAIT, WRITEBACK; instr_ready=1 only in IDLE.
REQ-021 SHALL accept an instruction on a rising edge when instr_valid=1 and state=IDLE, capturing opcode, rt, rd, immediate, alu_result.
REQ-022 SHALL decode: 000000 R-type (dest rd, data alu_result); 001111 LUI (dest rt, data {immediate,16'h0000}); 100011 LW (dest rt, data mem_rdata); any other opcode accepted, no write, stays IDLE.
REQ-023 SHALL move IDLE->WRITEBACK on accepted R-type/LUI, so reg_write asserts the cycle after acceptance (latency 1).
REQ-024 SHALL move IDLE->MEM_WAIT on accepted LW; mem_req=1 and mem_addr=captured alu_result throughout MEM_WAIT.
REQ-025 SHALL, in MEM_WAIT with mem_ready=1, capture mem_rdata and move to WRITEBACK; mem_req deasserts the following cycle.
REQ-026 SHALL count MEM_WAIT cycles with mem_ready=0 (8-bit counter, cleared on MEM_WAIT entry); on reaching MEM_TIMEOUT, set mem_error, return to IDLE with no write.
REQ-027 SHALL give mem_ready priority over timeout when both occur in the same cycle.
REQ-028 SHALL hold WRITEBACK exactly one cycle with reg_write=1, write_reg/write_data driven from captured values, then return to IDLE.
REQ-029 SHALL force reg_write=0 when destination is register 0; sequencing and latency unchanged.
REQ-030 SHALL drive lui_control_signal=1 only in WRITEBACK of a LUI; 0 otherwise.
REQ-031 SHALL keep mem_error set until reset; it does not block further instructions.
REQ-032 SHALL ignore instr_valid and mem_ready outside the states that consume them.

Reset
REQ-033 SHALL on reset (any time, including mid-MEM_WAIT or WRITEBACK) immediately enter IDLE: instr_ready=1 after release, mem_req=0, mem_addr=0, reg_write=0, write_reg=0, write_data=0, lui_control_signal=0, mem_error=0, counter=0.

Verification
REQ-034 SHALL cover LUI: opcode=001111, rt=5, immediate=16'hFFFF accepted -> next cycle reg_write=1, write_reg=5, write_data=32'hFFFF0000, lui_control_signal=1; next cycle IDLE.
REQ-035 SHALL cover LW: opcode=100011, rt=8, alu_result=32'h00000040, mem_ready after 3 cycles with mem_rdata=32'h55555555 -> mem_req high 3 cycles... until ready, mem_addr=32'h40, then reg_write=1, write_data=32'h55555555.
REQ-036 SHALL cover timeout: LW with mem_ready held 0 -> after MEM_TIMEOUT (15) cycles mem_error=1, state IDLE, no reg_write pulse; subsequent R-type still writes.
REQ-037 SHALL cover mem_ready coincident with final timeout cycle -> write occurs, mem_error stays 0.
REQ-038 SHALL cover R-type with rd=0 and alu_result=32'h12345678 -> reg_write stays 0, instr_ready low exactly one cycle.
REQ-039 SHALL cover reset asserted mid-MEM_WAIT -> outputs at reset values asynchronously, no later write from aborted load.
